// File: rtl/mem_wb_skid_reg_if.sv
// mem_wb_skid_reg_if: valid/ready/data handshake bundle used on both sides of the MEM->WB skid register.
interface mem_wb_skid_reg_if #(parameter int W = 102);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_wb_skid_reg.sv
// mem_wb_skid_reg: MEM->WB pipeline register with valid/ready handshake, freeze, flush and a 2-entry skid buffer.
// Define MEM_WB_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_wb_skid_reg #(
    parameter int PAYLOAD_W = 102
`ifdef MEM_WB_STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    mem_wb_skid_reg_if.slave  in_if,
    mem_wb_skid_reg_if.master out_if
`ifdef MEM_WB_STALL_CNT_EN
    , output logic [CNT_W-1:0] stall_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t               r_state, w_next;
    logic [PAYLOAD_W-1:0] r_main, r_skid;
    logic                 w_out_valid, w_accept, w_consume, w_ld_main, w_ld_skid, w_from_skid;
    // ready depends only on registered state and global controls, never on out_ready
    assign in_if.ready  = !rst && r_state != FULL && !freeze && !flush;
    assign w_out_valid  = r_state != EMPTY;
    assign out_if.valid = w_out_valid;
    assign out_if.data  = r_main;
    assign w_accept     = in_if.valid && in_if.ready;
    assign w_consume    = w_out_valid && out_if.ready && !freeze;
    always_comb begin
        w_next      = r_state;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
        w_from_skid = 1'b0;
        if (flush)
            w_next = EMPTY;
        else
            case (r_state)
                EMPTY: begin
                    w_ld_main = w_accept;
                    w_next    = w_accept ? ONE : EMPTY;
                end
                ONE: begin
                    w_ld_main = w_accept && w_consume;
                    w_ld_skid = w_accept && !w_consume;
                    w_next    = w_ld_skid ? FULL : (w_consume && !w_accept) ? EMPTY : ONE;
                end
                FULL: begin
                    w_ld_main   = w_consume;
                    w_from_skid = w_consume;
                    w_next      = w_consume ? ONE : FULL;
                end
                default: w_next = EMPTY;
            endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_main) r_main <= w_from_skid ? r_skid : in_if.data;
            if (w_ld_skid) r_skid <= in_if.data;
        end
    end
`ifdef MEM_WB_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    // flush deliberately leaves the count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_out_valid && !out_if.ready && !freeze && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end
    assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// tb_mem_wb_skid_reg: table-driven bench with a payload scoreboard for mem_wb_skid_reg.
module tb_mem_wb_skid_reg;
    localparam int W = 102;
    logic clk = 1'b0, rst = 1'b1, freeze = 1'b0, flush = 1'b0;
    mem_wb_skid_reg_if #(.W(W)) up();
    mem_wb_skid_reg_if #(.W(W)) dn();
`ifdef MEM_WB_STALL_CNT_EN
    logic [1:0] stall_cnt;
    mem_wb_skid_reg #(.PAYLOAD_W(W), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_if(up), .out_if(dn), .stall_cnt(stall_cnt));
`else
    mem_wb_skid_reg #(.PAYLOAD_W(W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .in_if(up), .out_if(dn));
`endif
    always #5 clk = ~clk;
    typedef struct {
        logic       iv;
        logic [7:0] din;
        logic       ordy, frz, fl, er, ev;
    } vec_t;
    vec_t           vecs[$];
    logic [W-1:0]   sb[$];
    int             checks = 0, errors = 0;
    function automatic logic [W-1:0] mk(input logic [7:0] b);
        logic [103:0] t;
        t = {13{b}};
        return t[W-1:0];
    endfunction
    function automatic vec_t v(input logic iv, input logic [7:0] din, input logic ordy, frz, fl, er, ev);
        vec_t r;
        r.iv = iv; r.din = din; r.ordy = ordy; r.frz = frz; r.fl = fl; r.er = er; r.ev = ev;
        return r;
    endfunction
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cycle(input vec_t x);
        up.valid = x.iv; up.data = mk(x.din); dn.ready = x.ordy; freeze = x.frz; flush = x.fl;
        @(negedge clk);
        chk("in_ready", W'(up.ready), W'(x.er));
        chk("out_valid", W'(dn.valid), W'(x.ev));
        if (x.ev) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: out_valid expected but scoreboard has no entry at %0t", $time);
            end else chk("out_data", dn.data, sb[0]);
        end
        if (x.fl) sb.delete();
        else if (!x.frz) begin
            if (x.ev && x.ordy) void'(sb.pop_front());
            if (x.iv && x.er) sb.push_back(mk(x.din));
        end
        @(posedge clk); #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        // T2 streaming
        for (int k = 1; k <= 8; k++) vecs.push_back(v(1, 8'(k), 1, 0, 0, 1, k > 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
        // T3 back-pressure into FULL, T4 freeze then drain
        vecs.push_back(v(1, 8'h11, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 8'h22, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 8'h33, 0, 0, 0, 0, 1));
        for (int k = 0; k < 3; k++) vecs.push_back(v(1, 8'h44, 1, 1, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
        // T5 flush with freeze in FULL; 0x77 must never appear
        vecs.push_back(v(1, 8'h55, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 8'h66, 0, 0, 0, 1, 1));
        vecs.push_back(v(1, 8'h77, 1, 1, 1, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
        vecs.push_back(v(1, 8'h88, 1, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 0));
        // flush alone from ONE
        vecs.push_back(v(1, 8'h99, 0, 0, 0, 1, 0));
        vecs.push_back(v(1, 8'haa, 0, 0, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 0));
        // T1 reset with in_valid asserted
        up.valid = 1'b1; up.data = mk(8'h5a); dn.ready = 1'b1;
        #2;
        chk("rst_out_valid", W'(dn.valid), '0);
        chk("rst_out_data", dn.data, '0);
        chk("rst_in_ready", W'(up.ready), '0);
        @(posedge clk); @(negedge clk);
        chk("rst_hold_out_valid", W'(dn.valid), '0);
        chk("rst_hold_in_ready", W'(up.ready), '0);
        up.valid = 1'b0; rst = 1'b0;
        #1;
        chk("post_rst_in_ready", W'(up.ready), W'(1));
        @(posedge clk); #1;
        foreach (vecs[i]) cycle(vecs[i]);
        // reset mid-transfer discards a FULL buffer
        cycle(v(1, 8'hc1, 0, 0, 0, 1, 0));
        cycle(v(1, 8'hc2, 0, 0, 0, 1, 1));
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", W'(dn.valid), '0);
        chk("mid_rst_out_data", dn.data, '0);
        chk("mid_rst_in_ready", W'(up.ready), '0);
        up.valid = 1'b0;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        cycle(v(0, 0, 1, 0, 0, 1, 0));
`ifdef MEM_WB_STALL_CNT_EN
        // T6 saturating stall counter, untouched by flush
        chk("cnt_after_rst", W'(stall_cnt), '0);
        cycle(v(1, 8'hd1, 0, 0, 0, 1, 0));
        chk("cnt_first_load", W'(stall_cnt), '0);
        for (int k = 1; k <= 5; k++) begin
            cycle(v(0, 0, 0, 0, 0, 1, 1));
            chk($sformatf("cnt_stall_%0d", k), W'(stall_cnt), W'(k < 3 ? k : 3));
        end
        cycle(v(0, 0, 0, 0, 1, 0, 1));
        chk("cnt_after_flush", W'(stall_cnt), W'(3));
        cycle(v(0, 0, 1, 0, 0, 1, 0));
        chk("cnt_idle", W'(stall_cnt), W'(3));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
